lfsr_range_picker: RTL
======================

// Module: lfsr_range_picker
// PURPOSE
//  Consumes the free-running 8-bit pseudo-random byte from the LFSR stage every clock.
//  Maps it to an unbiased value in [0, range_in) using masked rejection sampling.
//  Buffers accepted values in a small FIFO behind a valid/ready handshake.
//  Game logic (spawn position, card draw) pops values on demand.
// PARAMETERS
//  DEPTH       4   FIFO entries, power of two, >=2
//  MAX_REJECT  4   consecutive rejections before the forced fallback value is pushed
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous reset, ACTIVE-HIGH (1 = reset) despite the suffix
//  rnd_in     in   8   LFSR byte, new value assumed every cycle
//  range_in   in   8   exclusive upper bound; 0 = disabled
//  out_ready  in   1   consumer pops when out_valid & out_ready
//  out_valid  out  1   FIFO non-empty
//  out_data   out  8   head of FIFO (show-ahead), always < latched range
//  level      out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, level=0, range_q=0, reject_cnt=0, state=IDLE.
//  FSM states:
//   IDLE : range_q==0. No pushes. range_in!=range_q -> FLUSH.
//   FLUSH: one cycle. Clears FIFO and reject_cnt. Latches range_q<=range_in. No push or pop.
//          Next state: FILL if range_in!=0, else IDLE.
//   FILL : sample every cycle. range_in!=range_q -> FLUSH, taking priority over push and pop that cycle.
//  Sampling in FILL:
//   mask = smallest 2^k-1 >= range_q-1 (range_q=1 -> mask=0).
//   cand = rnd_in & mask.
//   Accept if cand < range_q; push cand, reset reject_cnt.
//   On reject, reject_cnt++. If reject_cnt==MAX_REJECT-1 and cand is rejected, push cand-range_q
//   (valid, since cand<2*range_q) and reset reject_cnt.
//   No sample is taken while the FIFO is full with no pop that cycle. reject_cnt holds.
//  Latency: a value accepted in cycle N is visible on out_data with out_valid=1 in cycle N+1.
//   Empty-FIFO bypass is not provided.
//  Simultaneous push and pop:
//   full  -> both occur, level unchanged.
//   empty -> push only; the pop is a no-op because out_valid=0.
//  Pointers wrap modulo DEPTH. level saturates at DEPTH and never exceeds it.
//  out_data holds the last head value when empty. Its value is don't-care for checking while out_valid=0.
//  Reset mid-operation: asynchronous clear to the reset values above. Buffered values are discarded.
// CONFIGURATION
//  DUP_FILTER_EN defined:
//   An accepted cand equal to the last pushed value (last_q) is treated as a reject and counts toward MAX_REJECT.
//   The fallback value is pushed even if it is a duplicate.
//   The filter is bypassed when range_q==1.
//   last_q is invalidated on FLUSH and on reset.
//  DUP_FILTER_EN undefined:
//   No last_q register. Repeats are allowed.
// STRUCTURE
//  Package lfsr_pick_pkg: state enum {IDLE,FLUSH,FILL}, RND_W=8, a function mask_of(range).
//  Sub-module rng_fifo: parameterised DEPTH x 8 show-ahead FIFO with push/pop/clear/level.
//   The picker holds the FSM, masking, reject counter and dup filter.
// TESTING
//  1 Reset: rst_n=1 mid-stream with FIFO holding 3 entries.
//    -> out_valid=0 and level=0 in the same cycle, asynchronously.
//  2 range_in=6 (mask=7), rnd_in=0x0D,0x0E,0x03.
//    -> push 5, reject, push 3. Out sequence is 5,3 with 1-cycle latency.
//  3 range_in=5, rnd_in=0x07 held, MAX_REJECT=4.
//    -> 3 rejects, then 2 pushed on the 4th cycle. Repeats every 4 cycles.
//  4 out_ready=0 with a continuous accept stream.
//    -> level stops at 4 and sampling stalls.
//    -> out_ready=1 for 1 cycle: level stays 4 and the head advances.
//  5 FIFO holds values for range 6; range_in changes to 3.
//    -> one FLUSH cycle with out_valid=0; all later out_data < 3.
//  6 DUP_FILTER_EN, range 4, rnd_in=1,1,2 -> pushes 1,2 (second 1 rejected).
//    range_in=1 -> all zeros accepted.

Source files
------------

// File: rtl/lfsr_range_picker_pkg.sv
// Shared types and helpers for lfsr_range_picker: FSM state encoding and the
// rejection-sampling mask function.
package lfsr_pick_pkg;

    localparam int RND_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        FILL  = 2'd2
    } state_t;

    // Smallest all-ones mask covering rng-1; rng of 0 or 1 yields 0.
    function automatic logic [RND_W-1:0] mask_of(input logic [RND_W-1:0] rng);
        logic [RND_W-1:0] m;
        if (rng == 8'd0) begin
            m = 8'd0;
        end else begin
            m = rng - 8'd1;
        end
        m = m | (m >> 3'd1);
        m = m | (m >> 3'd2);
        m = m | (m >> 3'd4);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_range_picker_fifo.sv
// rng_fifo: DEPTH x W show-ahead FIFO with synchronous clear and occupancy output.
// Head entry is presented combinationally from the storage registers.
module rng_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against occupancy; a push into a full FIFO needs a same-cycle pop.
    always_comb begin
        pop_ok_s  = pop & (count_r != LW'(0));
        push_ok_s = push & ((count_r != LW'(DEPTH)) | pop_ok_s);
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == LW'(0));
    assign full  = (count_r == LW'(DEPTH));
    assign level = count_r;

endmodule

// File: rtl/lfsr_range_picker.sv
// lfsr_range_picker: maps an LFSR byte stream onto [0, range) by masked rejection
// sampling and buffers results in rng_fifo. Optional macro DUP_FILTER_EN rejects repeats.
module lfsr_range_picker
    import lfsr_pick_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MAX_REJECT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RND_W-1:0]       rnd_in,
    input  logic [RND_W-1:0]       range_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [RND_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int RC_W = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;

    state_t           state_r;
    state_t           state_nxt;
    logic [RND_W-1:0] range_q_r;
    logic [RC_W-1:0]  reject_cnt_r;
    logic [RC_W-1:0]  reject_cnt_nxt;

    logic             change_s;
    logic             clear_s;
    logic             fill_s;
    logic             pop_s;
    logic             sample_s;
    logic             push_s;
    logic [RND_W-1:0] push_data_s;
    logic [RND_W-1:0] cand_s;
    logic [RND_W-1:0] fallback_s;
    logic             in_range_s;
    logic             dup_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;

    assign change_s   = (range_in != range_q_r);
    assign cand_s     = rnd_in & mask_of(range_q_r);
    assign in_range_s = (cand_s < range_q_r);
    // A duplicate-rejected cand is already in range, so the fallback keeps it as is.
    assign fallback_s = in_range_s ? cand_s : (cand_s - range_q_r);

`ifdef DUP_FILTER_EN
    logic [RND_W-1:0] last_q_r;
    logic             last_valid_r;

    assign dup_s = last_valid_r & (range_q_r != 8'd1) & (cand_s == last_q_r);

    // Last pushed value, invalidated whenever the range is re-latched.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            last_q_r     <= 8'd0;
            last_valid_r <= 1'b0;
        end else if (state_r == FLUSH) begin
            last_q_r     <= 8'd0;
            last_valid_r <= 1'b0;
        end else if (push_s) begin
            last_q_r     <= push_data_s;
            last_valid_r <= 1'b1;
        end else begin
            last_q_r     <= last_q_r;
            last_valid_r <= last_valid_r;
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    // Next-state logic; the FIFO is emptied on the edge entering FLUSH so the
    // FLUSH cycle already presents an empty, invalid output.
    always_comb begin
        state_nxt = state_r;
        clear_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (change_s) begin
                    state_nxt = FLUSH;
                    clear_s   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                clear_s = 1'b1;
                if (range_in != 8'd0) begin
                    state_nxt = FILL;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FILL: begin
                if (change_s) begin
                    state_nxt = FLUSH;
                    clear_s   = 1'b1;
                end else begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = IDLE;
                clear_s   = 1'b1;
            end
        endcase
    end

    assign fill_s   = (state_r == FILL) & ~change_s;
    assign pop_s    = fill_s & out_ready & ~fifo_empty_s;
    assign sample_s = fill_s & (~fifo_full_s | pop_s);

    // Accept / reject / forced-fallback decision for this cycle's sample.
    always_comb begin
        push_s         = 1'b0;
        push_data_s    = cand_s;
        reject_cnt_nxt = reject_cnt_r;
        if (sample_s) begin
            if (in_range_s & ~dup_s) begin
                push_s         = 1'b1;
                push_data_s    = cand_s;
                reject_cnt_nxt = '0;
            end else if (reject_cnt_r == RC_W'(MAX_REJECT - 1)) begin
                push_s         = 1'b1;
                push_data_s    = fallback_s;
                reject_cnt_nxt = '0;
            end else begin
                push_s         = 1'b0;
                push_data_s    = cand_s;
                reject_cnt_nxt = reject_cnt_r + RC_W'(1);
            end
        end else begin
            push_s         = 1'b0;
            push_data_s    = cand_s;
            reject_cnt_nxt = reject_cnt_r;
        end
    end

    // FSM state, latched range and rejection counter.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r      <= IDLE;
            range_q_r    <= 8'd0;
            reject_cnt_r <= '0;
        end else begin
            state_r <= state_nxt;
            if (state_r == FLUSH) begin
                range_q_r    <= range_in;
                reject_cnt_r <= '0;
            end else begin
                range_q_r    <= range_q_r;
                reject_cnt_r <= reject_cnt_nxt;
            end
        end
    end

    rng_fifo #(
        .DEPTH (DEPTH),
        .W     (RND_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .clear (clear_s),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_data_s),
        .dout  (out_data),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .level (level)
    );

    assign out_valid = ~fifo_empty_s;

endmodule
